mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Run controller that sequences the MIPS_top processor. It streams a program/data image into the instruction and data caches through their write ports and asserts `start`. It then monitors `current_pc` for the terminal instruction address and reports completion or a watchdog timeout. It sits between the host/test harness and MIPS_top, replacing hand-sequenced cache writes.

## Interface
- `MAX_CYCLES`, 400: watchdog limit, in run cycles.
- `HIT_CYCLES`, 1: consecutive cycles with `current_pc == end_pc` required for done.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  load record valid.
- `ld_ready`  out  1  load record accepted when `ld_valid & ld_ready`.
- `ld_sel`  in  1  target: 0 = icache, 1 = dcache.
- `ld_addr`  in  32  word address.
- `ld_data`  in  32  word data.
- `ld_last`  in  1  final record of image.
- `go`  in  1  single-cycle run request.
- `end_pc`  in  32  terminal instruction address, sampled on accepted `go`.
- `current_pc`  in  32  from MIPS_top.
- `IAddr_in`, `IData_in`  out  32 each  icache write address/data.
- `icache_we`  out  1  icache write strobe.
- `DAddr_in`, `DData_in`  out  32 each  dcache write address/data.
- `dcache_we`  out  1  dcache write strobe.
- `start`  out  1  processor run enable.
- `busy`  out  1  high in LOAD, LOADED and RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  high in TIMEOUT.
- `cycle_count`  out  32  run cycles elapsed.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: receiving records.
  - LOADED: image complete.
  - RUN: processor running.
  - DONE, TIMEOUT: terminal states.
- `ld_ready` = 1 in IDLE, LOAD, DONE and TIMEOUT; 0 in LOADED and RUN.
- State transitions:
  - Accepted record without `ld_last` in IDLE/DONE/TIMEOUT → LOAD.
  - Accepted record with `ld_last` (any ready state) → LOADED. A one-record image goes IDLE → LOADED directly.
  - `go` in LOADED → RUN: latch `end_pc`, clear `cycle_count` and the hit counter.
  - `go` in any other state is ignored.
- Each accepted record produces exactly one write strobe on the selected cache. The other cache's strobe stays 0.
- Address/data outputs hold their last written value between writes.
- RUN:
  - Hit counter increments when `current_pc == end_pc`; otherwise it clears to 0.
  - `cycle_count` increments each cycle and saturates at 2^32−1.
  - Hit counter reaching `HIT_CYCLES` → DONE.
  - Otherwise, `cycle_count == MAX_CYCLES−1` → TIMEOUT.
  - Done wins if both occur in the same cycle.
- DONE/TIMEOUT: `cycle_count` holds. A new load returns via LOAD/LOADED; re-running requires reloading.
- A rerun with stale processor state is not supported.

## Timing
- Reset: state IDLE; all outputs 0, except `ld_ready` = 1 in the cycle after reset.
- Write latency: record accepted at edge N → registered address/data and `*_we` = 1 during cycle N+1, exactly one cycle.
- Back-to-back records give back-to-back single-cycle strobes with no bubble.
- `start` rises the cycle after `go` is accepted and stays high through RUN. It falls on the same edge that enters DONE/TIMEOUT.
- `done`/`timeout` are registered state decodes, high the cycle after the detecting edge.
- `rst` mid-load or mid-run: next edge forces IDLE, drops `start` and `*_we`, and discards any pending write.
- `go` and `ld_valid` together in LOADED: `ld_ready` = 0, so `go` wins and no record is consumed.

## Structure
- Package `mips_ctrl_pkg`: state enum, `LD_SEL_ICACHE` = 0 / `LD_SEL_DCACHE` = 1, default `MAX_CYCLES`.
- Sub-module `mips_run_watchdog`:
  - Contains the cycle counter and the hit counter.
  - Inputs: clear, enable, `pc_match`.
  - Outputs: `hit`, `expired`, `count`.
- FSM and cache write registers live in the top.

## Test plan
- Load 5 dcache words (addr 0..4 = 42, 23, 16, 8, 156), then 23 icache words (addr 0..22, last record with `ld_last`) → 28 single-cycle strobes with matching address/data; state LOADED; `ld_ready` = 0.
- `go` with `end_pc` = 22, insertion-sort image → `start` = 1, `done` asserted before cycle 400; dcache holds 8, 16, 23, 42, 156; `start` = 0.
- Image whose last instruction is a self-loop away from `end_pc` = 99 → `timeout` = 1 with `cycle_count` = 399; `done` = 0.
- `go` issued in IDLE and again mid-LOAD → ignored; no `start`; loading continues unaffected.
- `rst` pulsed 20 cycles into RUN → next cycle: state IDLE, all outputs 0, `ld_ready` = 1.
- `HIT_CYCLES` = 3 with PC hitting `end_pc` for 2 cycles, leaving, then 3 cycles → `done` only after the 3-cycle streak.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS_top run controller.
// Cache select encoding, controller states and default watchdog limits.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOADED,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } run_state_t;

   localparam logic LD_SEL_ICACHE = 1'b0;
   localparam logic LD_SEL_DCACHE = 1'b1;

   localparam int unsigned DEF_MAX_CYCLES = 400;
   localparam int unsigned DEF_HIT_CYCLES = 1;

endpackage

// File: rtl/mips_run_watchdog.sv
// Run-cycle counter and end-PC hit-streak counter for the run controller.
// o_hit / o_expired are look-ahead flags: the FSM acts on them at the same edge.
module mips_run_watchdog
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int unsigned HIT_CYCLES = DEF_HIT_CYCLES
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_enable,
   input  logic        i_pc_match,
   output logic        o_hit,
   output logic        o_expired,
   output logic [31:0] o_count
);

   localparam logic [31:0] LP_LAST_COUNT = 32'(MAX_CYCLES - 1);
   localparam logic [31:0] LP_HIT_PRE    = 32'(HIT_CYCLES - 1);

   logic [31:0] r_count;
   logic [31:0] r_hit_cnt;
   logic        w_at_limit;
   logic        w_streak_done;

   assign w_at_limit    = (r_count == LP_LAST_COUNT);
   // Current matching cycle completes the streak when HIT_CYCLES-1 already counted.
   assign w_streak_done = i_pc_match && (r_hit_cnt >= LP_HIT_PRE);

   assign o_hit     = i_enable && w_streak_done;
   assign o_expired = i_enable && w_at_limit;
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count   <= '0;
         r_hit_cnt <= '0;
      end else if (i_enable) begin
         // The count freezes on the expiry edge so it reads MAX_CYCLES-1 afterwards.
         if (!w_at_limit && (r_count != '1)) begin
            r_count <= r_count + 32'd1;
         end
         if (i_pc_match) begin
            if (r_hit_cnt != '1) begin
               r_hit_cnt <= r_hit_cnt + 32'd1;
            end
         end else begin
            r_hit_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: streams an image into the MIPS_top caches, starts the core,
// and watches current_pc for the terminal address or a watchdog timeout.
//
// state      | meaning
// ST_IDLE    | after reset, accepting records
// ST_LOAD    | image partially received
// ST_LOADED  | image complete, waiting for go
// ST_RUN     | processor running (start high)
// ST_DONE    | end_pc reached
// ST_TIMEOUT | watchdog expired
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int unsigned HIT_CYCLES = DEF_HIT_CYCLES
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic        i_ld_sel,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_data,
   input  logic        i_ld_last,
   input  logic        i_go,
   input  logic [31:0] i_end_pc,
   input  logic [31:0] i_current_pc,
   output logic [31:0] o_IAddr_in,
   output logic [31:0] o_IData_in,
   output logic        o_icache_we,
   output logic [31:0] o_DAddr_in,
   output logic [31:0] o_DData_in,
   output logic        o_dcache_we,
   output logic        o_start,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_timeout,
   output logic [31:0] o_cycle_count
);

   run_state_t  r_state;
   run_state_t  w_state_nxt;
   logic        w_ld_ready;
   logic        w_ld_acc;
   logic        w_go_acc;
   logic        w_run;
   logic        w_hit;
   logic        w_expired;
   logic [31:0] r_end_pc;
   logic [31:0] r_iaddr;
   logic [31:0] r_idata;
   logic [31:0] r_daddr;
   logic [31:0] r_ddata;
   logic        r_icache_we;
   logic        r_dcache_we;

   assign w_ld_acc = i_ld_valid && w_ld_ready;
   assign w_go_acc = i_go && (r_state == ST_LOADED);
   assign w_run    = (r_state == ST_RUN);

   mips_run_watchdog #(
      .MAX_CYCLES (MAX_CYCLES),
      .HIT_CYCLES (HIT_CYCLES)
   ) u_watchdog (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clear    (w_go_acc),
      .i_enable   (w_run),
      .i_pc_match (i_current_pc == r_end_pc),
      .o_hit      (w_hit),
      .o_expired  (w_expired),
      .o_count    (o_cycle_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_ready  = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_LOAD, ST_DONE, ST_TIMEOUT: begin
            w_ld_ready = 1'b1;
            if (i_ld_valid) begin
               w_state_nxt = i_ld_last ? ST_LOADED : ST_LOAD;
            end
         end
         ST_LOADED: begin
            if (i_go) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // A completed hit streak takes priority over a same-cycle expiry.
            if (w_hit) begin
               w_state_nxt = ST_DONE;
            end else if (w_expired) begin
               w_state_nxt = ST_TIMEOUT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_end_pc    <= '0;
         r_iaddr     <= '0;
         r_idata     <= '0;
         r_daddr     <= '0;
         r_ddata     <= '0;
         r_icache_we <= 1'b0;
         r_dcache_we <= 1'b0;
      end else begin
         r_icache_we <= 1'b0;
         r_dcache_we <= 1'b0;
         if (w_go_acc) begin
            r_end_pc <= i_end_pc;
         end
         if (w_ld_acc) begin
            if (i_ld_sel == LD_SEL_DCACHE) begin
               r_daddr     <= i_ld_addr;
               r_ddata     <= i_ld_data;
               r_dcache_we <= 1'b1;
            end else begin
               r_iaddr     <= i_ld_addr;
               r_idata     <= i_ld_data;
               r_icache_we <= 1'b1;
            end
         end
      end
   end

   assign o_ld_ready  = w_ld_ready;
   assign o_IAddr_in  = r_iaddr;
   assign o_IData_in  = r_idata;
   assign o_icache_we = r_icache_we;
   assign o_DAddr_in  = r_daddr;
   assign o_DData_in  = r_ddata;
   assign o_dcache_we = r_dcache_we;
   assign o_start     = w_run;
   assign o_busy      = (r_state == ST_LOAD) || (r_state == ST_LOADED) || w_run;
   assign o_done      = (r_state == ST_DONE);
   assign o_timeout   = (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl; the processor PC is driven directly.
// A second instance with HIT_CYCLES=3 shares the stimulus for the streak test.
module tb_mips_run_ctrl;

   logic        clk;
   logic        rst;
   logic        ld_valid;
   logic        ld_sel;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        go;
   logic [31:0] end_pc;
   logic [31:0] current_pc;

   logic        ld_ready, icache_we, dcache_we, start, busy, done, timeout;
   logic [31:0] iaddr, idata, daddr, ddata, cycle_count;

   logic        ld_ready2, icache_we2, dcache_we2, start2, busy2, done2, timeout2;
   logic [31:0] iaddr2, idata2, daddr2, ddata2, cycle_count2;

   int checks = 0;
   int errors = 0;

   mips_run_ctrl dut (
      .i_clk (clk), .i_rst (rst),
      .i_ld_valid (ld_valid), .o_ld_ready (ld_ready), .i_ld_sel (ld_sel),
      .i_ld_addr (ld_addr), .i_ld_data (ld_data), .i_ld_last (ld_last),
      .i_go (go), .i_end_pc (end_pc), .i_current_pc (current_pc),
      .o_IAddr_in (iaddr), .o_IData_in (idata), .o_icache_we (icache_we),
      .o_DAddr_in (daddr), .o_DData_in (ddata), .o_dcache_we (dcache_we),
      .o_start (start), .o_busy (busy), .o_done (done), .o_timeout (timeout),
      .o_cycle_count (cycle_count)
   );

   mips_run_ctrl #(.MAX_CYCLES (400), .HIT_CYCLES (3)) dut_hit3 (
      .i_clk (clk), .i_rst (rst),
      .i_ld_valid (ld_valid), .o_ld_ready (ld_ready2), .i_ld_sel (ld_sel),
      .i_ld_addr (ld_addr), .i_ld_data (ld_data), .i_ld_last (ld_last),
      .i_go (go), .i_end_pc (end_pc), .i_current_pc (current_pc),
      .o_IAddr_in (iaddr2), .o_IData_in (idata2), .o_icache_we (icache_we2),
      .o_DAddr_in (daddr2), .o_DData_in (ddata2), .o_dcache_we (dcache_we2),
      .o_start (start2), .o_busy (busy2), .o_done (done2), .o_timeout (timeout2),
      .o_cycle_count (cycle_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                       input logic last);
      ld_valid = 1'b1;
      ld_sel   = sel;
      ld_addr  = addr;
      ld_data  = data;
      ld_last  = last;
      tick();
      chk("dcache_we", {31'd0, dcache_we}, {31'd0, sel});
      chk("icache_we", {31'd0, icache_we}, {31'd0, ~sel});
      if (sel) begin
         chk("daddr", daddr, addr);
         chk("ddata", ddata, data);
      end else begin
         chk("iaddr", iaddr, addr);
         chk("idata", idata, data);
      end
   endtask

   logic [31:0] dvals [5] = '{32'd42, 32'd23, 32'd16, 32'd8, 32'd156};
   logic [31:0] hit_pcs [6] = '{32'd50, 32'd50, 32'd7, 32'd50, 32'd50, 32'd50};

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int found;
      int hit_at;

      rst = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
      ld_last = 1'b0; go = 1'b0; end_pc = '0; current_pc = '0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_we", {30'd0, icache_we, dcache_we}, 32'd0);
      chk("rst_count", cycle_count, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);

      // go while idle must be ignored
      go = 1'b1; end_pc = 32'd3;
      tick();
      go = 1'b0;
      chk("idle_go_start", {31'd0, start}, 32'd0);
      chk("idle_go_busy", {31'd0, busy}, 32'd0);
      chk("idle_go_ready", {31'd0, ld_ready}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         send(1'b1, 32'(i), dvals[i], 1'b0);
      end
      for (int i = 0; i < 23; i++) begin
         go = (i == 10);
         send(1'b0, 32'(i), 32'h2402_0000 | 32'(i), i == 22);
         if (i == 10) begin
            go = 1'b0;
            chk("midload_go_start", {31'd0, start}, 32'd0);
            chk("midload_go_busy", {31'd0, busy}, 32'd1);
         end
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      chk("loaded_ready", {31'd0, ld_ready}, 32'd0);
      chk("loaded_busy", {31'd0, busy}, 32'd1);
      chk("loaded_we", {30'd0, icache_we, dcache_we}, 32'd0);
      chk("hold_daddr", daddr, 32'd4);
      chk("hold_ddata", ddata, 32'd156);
      chk("hold_iaddr", iaddr, 32'd22);
      chk("hold_idata", idata, 32'h2402_0016);

      // go together with a record in LOADED: go wins, record not consumed
      go = 1'b1; end_pc = 32'd22; current_pc = 32'd0;
      ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 32'd77; ld_data = 32'hdead_beef;
      tick();
      go = 1'b0; ld_valid = 1'b0;
      chk("go_start", {31'd0, start}, 32'd1);
      chk("go_no_write", {30'd0, icache_we, dcache_we}, 32'd0);
      chk("go_iaddr_held", iaddr, 32'd22);
      chk("go_count", cycle_count, 32'd0);

      found = 0; hit_at = -1;
      for (int c = 0; c < 400; c++) begin
         current_pc = (c < 22) ? 32'(c) : 32'd22;
         tick();
         if (done) begin
            found = 1;
            hit_at = c;
            break;
         end
      end
      chk("done_seen", 32'(found), 32'd1);
      chk("done_cycle", 32'(hit_at), 32'd22);
      chk("done_count", cycle_count, 32'd23);
      chk("done_start", {31'd0, start}, 32'd0);
      chk("done_timeout", {31'd0, timeout}, 32'd0);
      chk("done_ready", {31'd0, ld_ready}, 32'd1);

      // one-record reload, then a self-loop that never reaches end_pc
      send(1'b0, 32'd0, 32'h1000_ffff, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("reload_busy", {31'd0, busy}, 32'd1);
      chk("reload_done", {31'd0, done}, 32'd0);
      go = 1'b1; end_pc = 32'd99; current_pc = 32'd5;
      tick();
      go = 1'b0;
      repeat (399) tick();
      chk("pre_timeout", {31'd0, timeout}, 32'd0);
      chk("pre_timeout_count", cycle_count, 32'd399);
      chk("pre_timeout_start", {31'd0, start}, 32'd1);
      tick();
      chk("timeout", {31'd0, timeout}, 32'd1);
      chk("timeout_count", cycle_count, 32'd399);
      chk("timeout_done", {31'd0, done}, 32'd0);
      chk("timeout_start", {31'd0, start}, 32'd0);
      tick();
      chk("timeout_count_hold", cycle_count, 32'd399);

      // reset 20 cycles into a run
      send(1'b1, 32'd9, 32'd9, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      go = 1'b1; end_pc = 32'd99;
      tick();
      go = 1'b0;
      repeat (20) tick();
      chk("run20_start", {31'd0, start}, 32'd1);
      chk("run20_count", cycle_count, 32'd20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrun_rst_start", {31'd0, start}, 32'd0);
      chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
      chk("midrun_rst_flags", {30'd0, done, timeout}, 32'd0);
      chk("midrun_rst_we", {30'd0, icache_we, dcache_we}, 32'd0);
      chk("midrun_rst_ready", {31'd0, ld_ready}, 32'd1);
      chk("midrun_rst_count", cycle_count, 32'd0);
      chk("midrun_rst_daddr", daddr, 32'd0);

      // HIT_CYCLES=3: a 2-cycle streak is broken, the next 3-cycle streak completes
      send(1'b0, 32'd0, 32'h0000_0001, 1'b1);
      ld_valid = 1'b0; ld_last = 1'b0;
      go = 1'b1; end_pc = 32'd50;
      tick();
      go = 1'b0;
      chk("hit3_start", {31'd0, start2}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         current_pc = hit_pcs[i];
         tick();
         chk($sformatf("hit3_done_%0d", i), {31'd0, done2}, {31'd0, i == 5});
      end
      chk("hit3_count", cycle_count2, 32'd6);
      chk("hit3_start_low", {31'd0, start2}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
